axi_write_arbiter: RTL
======================

# axi_write_arbiter

Write-channel controller for the AXI interconnect. It arbitrates the AW channel between M0 and M1 and decodes the address to S0 (IM), S1 (DM) or the default slave (DS). It then holds the grant for the whole transaction: AW handshake, W burst and B response. Its one-hot master and slave selects steer the Wdata mux and the B return path, so only one write is ever outstanding on the bus.

## Interface
Parameters:
- S0_BASE, 32'h0000_0000, S0 window base; window size 64 KiB.
- S1_BASE, 32'h0001_0000, S1 window base; window size 64 KiB. Any other address maps to DS.

Ports (widths use the codebase `AXI_*_BITS macros; S_AWID is `AXI_IDS_BITS = 8):
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset
- M0_AWID / M0_AWAddr / M0_AWLen / M0_AWSize / M0_AWBurst  input  ID/ADDR/LEN/SIZE/BURST  M0 write address
- M0_AWValid  input  1;  M0_AWReady  output  1
- M1_AWID / M1_AWAddr / M1_AWLen / M1_AWSize / M1_AWBurst  input  ID/ADDR/LEN/SIZE/BURST  M1 write address
- M1_AWValid  input  1;  M1_AWReady  output  1
- S_AWID  output  8  {master tag, M_AWID}; tag = 4'b0001 for M0, 4'b0010 for M1
- S_AWAddr / S_AWLen / S_AWSize / S_AWBurst  output  ADDR/LEN/SIZE/BURST  shared slave AW payload
- S0_AWValid, S1_AWValid, DS_AWValid  output  1 each;  S0_AWReady, S1_AWReady, DS_AWReady  input  1 each
- W_Valid, W_Ready, W_Last  input  1 each  handshake monitor of the routed W path (from the Wdata mux)
- B_Valid, B_Ready  input  1 each  handshake monitor of the routed B path
- W_Master_sel  output  2  one-hot {M1,M0}; selects the W source and B destination
- W_Slave_sel  output  3  one-hot {DS,S1,S0}; same encoding as the Wdata slave select
- Busy  output  1  high in any state except IDLE

## Operation
The controller is a four-state FSM: IDLE, ADDR, WDATA, BRESP.

- **IDLE**
  - All valid, ready and select outputs are 0.
  - If any M_AWValid is high, arbitrate, then register the grant and the decoded slave selected by the winner's address.
  - Next state: ADDR.
- **ADDR**
  - S_AW* are driven combinationally from the granted master.
  - The decoded Sx_AWValid equals the granted M_AWValid.
  - The granted M_AWReady equals the decoded Sx_AWReady. The other master's AWReady is 0.
  - On the AW handshake, go to WDATA.
  - If the granted master deasserts AWValid (a protocol violation), stay in ADDR.
- **WDATA**
  - W_Master_sel and W_Slave_sel are driven.
  - On W_Valid & W_Ready & W_Last, go to BRESP. Non-last beats keep the FSM in WDATA.
  - B handshakes are ignored in this state.
- **BRESP**
  - W_Master_sel is held; W_Slave_sel is held for B routing.
  - On B_Valid & B_Ready, go to IDLE and update last_grant.
- **Decode:** addr[31:16]==S0_BASE[31:16] selects S0; addr[31:16]==S1_BASE[31:16] selects S1; anything else selects DS. Decode uses the winner's address in the IDLE grant cycle; the result is registered.
- **Arbitration:** see Configuration. last_grant records the most recently served master.

## Timing
- **Reset** (rst==0 at a rising edge) forces:
  - state = IDLE, last_grant = M1, selects = 0, Busy = 0;
  - all AWValid and AWReady outputs = 0, because they are gated by state.
- **Mid-transaction reset:** the block is back in IDLE with all outputs 0 on the next edge. In-flight beats are abandoned.
- **AW latency:** M_AWValid rising in IDLE at edge N gives Sx_AWValid at N+1. The earliest AW handshake is at edge N+1.
- **Minimum transaction length:** IDLE→ADDR 1 cycle, AW 1 cycle, W with AWLen+1 beats, B 1 cycle, back to IDLE 1 cycle. Total is AWLen+5 cycles with zero-wait slaves.
- **No back-to-back overlap:** a new grant is possible only from IDLE, one cycle after the B handshake.
- **Simultaneous requests in IDLE:** resolved in the same cycle. The loser's AWReady stays 0 until it is later granted.
- S_AW* payload outside ADDR is a don't-care; the block drives the granted master's fields.

## Configuration
- WARB_ROUND_ROBIN_EN defined: round robin. When both masters request, the master that is not last_grant wins. A single requester always wins.
- Not defined: fixed priority, M1 (the CPU data port) always beats M0. last_grant is still maintained but unused.

## Test plan
- **Reset check:** hold rst low for 3 cycles with both AWValid high → every output is 0 and Busy=0. Release → grant on the next edge.
- **Single M1 write, DM path:** AWAddr=32'h0001_0040, AWLen=3 → S1_AWValid=1 and S_AWID=8'h2X. W_Slave_sel=3'b010 for 4 beats, then BRESP. Busy falls exactly 1 cycle after the B handshake; 8 cycles total with zero-wait slaves.
- **Default slave:** M0 AWAddr=32'h8000_0000 → DS_AWValid=1 and W_Slave_sel=3'b100. S0_AWValid and S1_AWValid stay 0 throughout.
- **Contention:** both masters request continuously for 4 transactions.
  - With WARB_ROUND_ROBIN_EN: grant order M0, M1, M0, M1.
  - Without it: grant order M1, M1, M1, M1.
- **Stall and spurious B:** S0_AWReady low for 5 cycles → stay in ADDR with M0_AWReady=0. Pulse B_Valid&B_Ready during WDATA → no state change.
- **Mid-burst reset:** assert rst on beat 2 of an AWLen=7 burst → IDLE next edge, W_Master_sel=0. The next request is served normally.

Source files
------------

// File: rtl/axi_write_arbiter.sv
// ---------------------------------------------------------------------------
// axi_write_arbiter
//
// Write-channel controller for the AXI interconnect. Arbitrates the AW
// channel between M0 and M1, decodes the winner's address to S0 (IM),
// S1 (DM) or the default slave (DS), and holds the grant for the whole
// transaction (AW handshake, W burst, B response). Only one write is ever
// outstanding on the bus.
//
// Configuration macro: WARB_ROUND_ROBIN_EN
//   defined   -> round robin between M0 and M1 on contention
//   undefined -> fixed priority, M1 always beats M0
//
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   M0_AW*, M1_AW*                 master write-address channels
//   S_AWID / S_AWAddr / S_AWLen /
//   S_AWSize / S_AWBurst           shared slave AW payload
//   S0/S1/DS_AWValid, _AWReady     per-slave AW handshake
//   W_Valid / W_Ready / W_Last     monitor of the routed W path
//   B_Valid / B_Ready              monitor of the routed B path
//   W_Master_sel                   one-hot {M1,M0}: W source / B destination
//   W_Slave_sel                    one-hot {DS,S1,S0}: W target / B source
//   Busy                           high whenever a transaction is in flight
// ---------------------------------------------------------------------------
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_BURST_BITS
`define AXI_BURST_BITS 2
`endif

module axi_write_arbiter #(
  parameter logic [31:0] S0_BASE = 32'h0000_0000,
  parameter logic [31:0] S1_BASE = 32'h0001_0000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [`AXI_ID_BITS-1:0]     M0_AWID,
  input  logic [`AXI_ADDR_BITS-1:0]   M0_AWAddr,
  input  logic [`AXI_LEN_BITS-1:0]    M0_AWLen,
  input  logic [`AXI_SIZE_BITS-1:0]   M0_AWSize,
  input  logic [`AXI_BURST_BITS-1:0]  M0_AWBurst,
  input  logic                        M0_AWValid,
  output logic                        M0_AWReady,
  input  logic [`AXI_ID_BITS-1:0]     M1_AWID,
  input  logic [`AXI_ADDR_BITS-1:0]   M1_AWAddr,
  input  logic [`AXI_LEN_BITS-1:0]    M1_AWLen,
  input  logic [`AXI_SIZE_BITS-1:0]   M1_AWSize,
  input  logic [`AXI_BURST_BITS-1:0]  M1_AWBurst,
  input  logic                        M1_AWValid,
  output logic                        M1_AWReady,
  output logic [`AXI_IDS_BITS-1:0]    S_AWID,
  output logic [`AXI_ADDR_BITS-1:0]   S_AWAddr,
  output logic [`AXI_LEN_BITS-1:0]    S_AWLen,
  output logic [`AXI_SIZE_BITS-1:0]   S_AWSize,
  output logic [`AXI_BURST_BITS-1:0]  S_AWBurst,
  output logic                        S0_AWValid,
  output logic                        S1_AWValid,
  output logic                        DS_AWValid,
  input  logic                        S0_AWReady,
  input  logic                        S1_AWReady,
  input  logic                        DS_AWReady,
  input  logic                        W_Valid,
  input  logic                        W_Ready,
  input  logic                        W_Last,
  input  logic                        B_Valid,
  input  logic                        B_Ready,
  output logic [1:0]                  W_Master_sel,
  output logic [2:0]                  W_Slave_sel,
  output logic                        Busy
);

  localparam logic [15:0] S0_PAGE = S0_BASE[31:16];
  localparam logic [15:0] S1_PAGE = S1_BASE[31:16];

  typedef enum logic [1:0] {IDLE, ADDR, WDATA, BRESP} state_t;

  state_t      state;
  logic [1:0]  grant;          // one-hot {M1,M0}, registered in the IDLE grant cycle
  logic [2:0]  slv;            // one-hot {DS,S1,S0}, decoded from the winner's address
  logic        last_grant_m1;  // 1: M1 was served most recently
  logic        busy_r;
  logic [1:0]  msel_r;
  logic [2:0]  ssel_r;

  logic        m1_first;
  logic [1:0]  win;
  logic [15:0] win_page;
  logic        g_valid;
  logic        s_ready;
  logic        in_addr;
  logic        aw_hs;

  function automatic logic [2:0] decode(input logic [15:0] page);
    if (page == S0_PAGE)      decode = 3'b001;
    else if (page == S1_PAGE) decode = 3'b010;
    else                      decode = 3'b100;
  endfunction

`ifdef WARB_ROUND_ROBIN_EN
  // On contention the master that was not served last goes first.
  assign m1_first = ~last_grant_m1;
`else
  // Fixed priority: M1 always wins; last_grant is tracked but does not steer.
  assign m1_first = last_grant_m1 | 1'b1;
`endif

  always_comb begin
    win = 2'b00;
    if (M0_AWValid && M1_AWValid) win = m1_first ? 2'b10 : 2'b01;
    else if (M1_AWValid)          win = 2'b10;
    else if (M0_AWValid)          win = 2'b01;
    win_page = win[1] ? M1_AWAddr[31:16] : M0_AWAddr[31:16];
  end

  // AW channel: valid/ready pass straight through between the granted
  // master and the decoded slave while in ADDR; everything else sees 0.
  assign in_addr = (state == ADDR);
  assign g_valid = grant[1] ? M1_AWValid : M0_AWValid;
  assign s_ready = |(slv & {DS_AWReady, S1_AWReady, S0_AWReady});
  assign aw_hs   = in_addr & g_valid & s_ready;

  assign S0_AWValid = in_addr & slv[0] & g_valid;
  assign S1_AWValid = in_addr & slv[1] & g_valid;
  assign DS_AWValid = in_addr & slv[2] & g_valid;
  assign M0_AWReady = in_addr & grant[0] & s_ready;
  assign M1_AWReady = in_addr & grant[1] & s_ready;

  // The master tag is the one-hot grant itself: 4'b0001 for M0, 4'b0010 for M1.
  assign S_AWID    = {{(`AXI_IDS_BITS-`AXI_ID_BITS-2){1'b0}}, grant,
                      grant[1] ? M1_AWID : M0_AWID};
  assign S_AWAddr  = grant[1] ? M1_AWAddr  : M0_AWAddr;
  assign S_AWLen   = grant[1] ? M1_AWLen   : M0_AWLen;
  assign S_AWSize  = grant[1] ? M1_AWSize  : M0_AWSize;
  assign S_AWBurst = grant[1] ? M1_AWBurst : M0_AWBurst;

  assign W_Master_sel = msel_r;
  assign W_Slave_sel  = ssel_r;
  assign Busy         = busy_r;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      grant         <= 2'b00;
      slv           <= 3'b000;
      last_grant_m1 <= 1'b1;
      busy_r        <= 1'b0;
      msel_r        <= 2'b00;
      ssel_r        <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (|win) begin
            grant  <= win;
            slv    <= decode(win_page);
            busy_r <= 1'b1;
            state  <= ADDR;
          end
        end
        ADDR: begin
          // A master that drops AWValid simply leaves us waiting here.
          if (aw_hs) begin
            msel_r <= grant;
            ssel_r <= slv;
            state  <= WDATA;
          end
        end
        WDATA: begin
          if (W_Valid && W_Ready && W_Last) state <= BRESP;
        end
        BRESP: begin
          if (B_Valid && B_Ready) begin
            last_grant_m1 <= grant[1];
            msel_r        <= 2'b00;
            ssel_r        <= 3'b000;
            busy_r        <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
